// File: rtl/fpu_pkg.sv
// Shared FPU constants.
// The exponent comparator of the single-precision FPU works on 8-bit exponents.
package fpu_pkg;
  localparam int FPU_EXP_WIDTH = 8;
endpackage

// File: rtl/fpu_abs_sub.sv
// Combinational signed subtract with magnitude, sign and range flag.
// The subtraction is one bit wider than the operands, so it never wraps.
module fpu_abs_sub #(
  parameter int size = 8
) (
  input  logic [size-1:0] a_i,
  input  logic [size-1:0] b_i,
  output logic [size-1:0] diff_o,
  output logic            sign_o,
  output logic            ovf_o
);
  logic [size:0] d;
  logic [size:0] mag;

  always_comb begin
    d      = {a_i[size-1], a_i} - {b_i[size-1], b_i};
    sign_o = d[size];
    mag    = d[size] ? (~d + 1'b1) : d;
    diff_o = mag[size-1:0];
    // |d| never exceeds 2^size-1, so mag[size] only matters for completeness.
    ovf_o  = mag[size] | mag[size-1];
  end
endmodule

// File: rtl/fpu_comparator.sv
// Registered signed comparator: |a-b|, a<b and out-of-range flag, one cycle latency.
// Results hold while no new sample is presented.
module fpu_comparator
  import fpu_pkg::*;
#(
  parameter int size = FPU_EXP_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            in_valid,
  output logic [size-1:0] difference,
  output logic            sign,
  output logic            overflow,
  output logic            out_valid
);
  logic [size-1:0] diff_d, diff_q;
  logic            sign_d, sign_q;
  logic            ovf_d, ovf_q;
  logic            valid_q;

  fpu_abs_sub #(.size(size)) u_abs_sub (
    .a_i    (a),
    .b_i    (b),
    .diff_o (diff_d),
    .sign_o (sign_d),
    .ovf_o  (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= diff_d;
        sign_q <= sign_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign difference = diff_q;
  assign sign       = sign_q;
  assign overflow   = ovf_q;
  assign out_valid  = valid_q;
endmodule

// File: tb/tb_fpu_comparator.sv
// Self-checking bench for fpu_comparator (size 8): integer reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_fpu_comparator;
  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            in_valid = 1'b0;
  logic [SIZE-1:0] difference;
  logic            sign;
  logic            overflow;
  logic            out_valid;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  // Reference model state (what the outputs must show after each edge)
  int m_diff = 0;
  int m_sign = 0;
  int m_ovf = 0;
  int m_valid = 0;

  fpu_comparator #(.size(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .difference (difference),
    .sign       (sign),
    .overflow   (overflow),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: exact integer arithmetic on the signed operand values.
  always @(posedge clk) begin
    int ai, bi, d;
    ai = int'($signed(a));
    bi = int'($signed(b));
    d  = ai - bi;
    if (rst) begin
      m_diff <= 0; m_sign <= 0; m_ovf <= 0; m_valid <= 0;
    end else begin
      m_valid <= in_valid ? 1 : 0;
      if (in_valid) begin
        m_diff <= (d < 0) ? -d : d;
        m_sign <= (d < 0) ? 1 : 0;
        m_ovf  <= (((d < 0) ? -d : d) >= (1 << (SIZE-1))) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_diff", int'(difference), m_diff);
      check("model_sign", int'(sign), m_sign);
      check("model_ovf", int'(overflow), m_ovf);
      check("model_valid", int'(out_valid), m_valid);
    end
  end

  task automatic vec(input int av, input int bv, input int ed, input int es, input int eo);
    @(posedge clk); #1;
    a = SIZE'(av); b = SIZE'(bv); in_valid = 1'b1;
    @(posedge clk); #1;
    check($sformatf("vec_diff(%0d,%0d)", av, bv), int'(difference), ed);
    check($sformatf("vec_sign(%0d,%0d)", av, bv), int'(sign), es);
    check($sformatf("vec_ovf(%0d,%0d)", av, bv), int'(overflow), eo);
    check($sformatf("vec_valid(%0d,%0d)", av, bv), int'(out_valid), 1);
  endtask

  initial begin
    // Reset held 2 cycles with a competing sample that must be discarded
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; a = SIZE'(-100); b = SIZE'(100);
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_diff", int'(difference), 0);
    check("rst_sign", int'(sign), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_valid", int'(out_valid), 0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", int'(out_valid), 0);
    check("post_rst_diff", int'(difference), 0);

    vec(0, 0, 0, 0, 0);
    vec(0, 1, 1, 1, 0);
    vec(1, 0, 1, 0, 0);
    vec(-1, 1, 2, 1, 0);
    vec(1, -1, 2, 0, 0);
    vec(0, -1, 1, 0, 0);
    vec(127, 0, 127, 0, 0);
    vec(-127, 1, 128, 1, 1);
    vec(2, -127, 129, 0, 1);
    vec(-128, 127, 255, 1, 1);
    vec(127, -128, 255, 0, 1);
    vec(-128, -128, 0, 0, 0);
    vec(5, 5, 0, 0, 0);

    // Three back-to-back samples then two idle cycles
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    a = SIZE'(10); b = SIZE'(3); in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_v0", int'(out_valid), 1);
    check("b2b_d0", int'(difference), 7);
    a = SIZE'(-20); b = SIZE'(20);
    @(posedge clk); #1;
    check("b2b_v1", int'(out_valid), 1);
    check("b2b_d1", int'(difference), 40);
    a = SIZE'(-100); b = SIZE'(60);
    @(posedge clk); #1;
    check("b2b_v2", int'(out_valid), 1);
    in_valid = 1'b0; a = SIZE'(0); b = SIZE'(0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_valid%0d", i), int'(out_valid), 0);
      check($sformatf("hold_diff%0d", i), int'(difference), 160);
      check($sformatf("hold_sign%0d", i), int'(sign), 1);
      check($sformatf("hold_ovf%0d", i), int'(overflow), 1);
    end

    // Reset in mid-stream discards the sample and clears outputs
    in_valid = 1'b1; rst = 1'b1; a = SIZE'(50); b = SIZE'(-50);
    @(posedge clk); #1;
    check("rst2_valid", int'(out_valid), 0);
    check("rst2_diff", int'(difference), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_after_rst", int'(difference), 100);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_comparator.md
FPU_COMPARATOR -- requirements
Module: fpu_comparator

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port a, input, size bits, operand A in two's complement (signed).
REQ-005 The block SHALL have port b, input, size bits, operand B in two's complement (signed).
REQ-006 The block SHALL have port in_valid, input, 1 bit; when high, a and b are sampled this cycle.
REQ-007 The block SHALL have port difference, output, size bits, unsigned magnitude |a-b|.
REQ-008 The block SHALL have port sign, output, 1 bit; 1 when a < b, else 0.
REQ-009 The block SHALL have port overflow, output, 1 bit; 1 when |a-b| > 2^(size-1)-1.
REQ-010 The block SHALL have port out_valid, output, 1 bit; high for one cycle when difference, sign and overflow carry a new result.

Function
REQ-011 The block SHALL compute the exact difference d = a - b at size+1 bits, so no intermediate wrap.
REQ-012 The block SHALL set sign to the sign bit of d: 1 if a < b, 0 if a >= b; a == b gives sign 0.
REQ-013 The block SHALL set difference to the low size bits of |d|; the maximum |d| = 2^size - 1 always fits.
REQ-014 The block SHALL set overflow to 1 exactly when |d| >= 2^(size-1); for size 8 that is |d| >= 128.
REQ-015 Latency SHALL be one cycle: inputs sampled with in_valid high at edge N appear on the outputs after edge N, and out_valid is high for that cycle.
REQ-016 When in_valid is low, out_valid SHALL be 0 and difference, sign and overflow SHALL hold their last values.
REQ-017 The block SHALL accept back-to-back in_valid every cycle with no stall; there is no ready signal.
REQ-018 Operands SHALL be treated symmetrically: swapping a and b yields the same difference and overflow, and inverts sign unless a == b.
REQ-019 Extreme operands SHALL be exact: a = -2^(size-1), b = 2^(size-1)-1 gives difference 2^size-1, sign 1, overflow 1.

Reset
REQ-020 While rst is high at a clock edge, the block SHALL set difference = 0, sign = 0, overflow = 0 and out_valid = 0.
REQ-021 rst SHALL take priority over a simultaneous in_valid; that sample is discarded.
REQ-022 The first result after reset release SHALL come from the first in_valid sampled with rst low.

Structure
REQ-023 The default width constant (8) SHALL live in the shared FPU package fpu_pkg; no typedefs are required.
REQ-024 The combinational subtract/absolute-value/flag logic MAY be placed in one sub-module, fpu_abs_sub; the output registers SHALL be in fpu_comparator.
REQ-025 fpu_comparator SHALL be usable as the exponent comparator of the single-precision FPU by setting size = 8.

Verification (size = 8, in_valid high, result checked one cycle later)
REQ-026 Hold rst high for 2 cycles -> all outputs 0, out_valid 0; an in_valid in the same cycle is ignored.
REQ-027 a=0,b=0 -> diff 0, sign 0, ovf 0. a=0,b=1 -> diff 1, sign 1, ovf 0. a=1,b=0 -> diff 1, sign 0, ovf 0.
REQ-028 a=-1,b=1 -> diff 2, sign 1, ovf 0. a=1,b=-1 -> diff 2, sign 0, ovf 0. a=0,b=-1 -> diff 1, sign 0, ovf 0.
REQ-029 a=127,b=0 -> diff 127, sign 0, ovf 0. a=-127,b=1 -> diff 128, sign 1, ovf 1. a=2,b=-127 -> diff 129, sign 0, ovf 1.
REQ-030 a=-128,b=127 -> diff 255, sign 1, ovf 1; the swapped operands give diff 255, sign 0, ovf 1.
REQ-031 Drive in_valid for 3 consecutive cycles, then low for 2 -> out_valid pattern 1,1,1,0,0, and the outputs hold the third result.
